// File: rtl/mem_bus_arbiter_if.sv
// Handshake/bus bundle for mem_bus_arbiter: Cpu and DMA requester ports plus the
// shared memory port. The arbiter connects through `slave`; the environment that
// drives requests and models memory uses `master`.
interface mem_bus_arbiter_if;
  // Cpu requester (requester 0)
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_done;

  // DMA requester (requester 1)
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_done;

  // Shared completion data/status
  logic [7:0]  rdata;
  logic        bus_err;

  // Memory port
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_done,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_done,
    output rdata, bus_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  // Requester / memory model side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_done,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_done,
    input  rdata, bus_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 16-bit address / 8-bit data memory port between the
// Cpu (requester 0, fixed priority) and a DMA engine (requester 1). One transaction
// at a time: IDLE picks a winner, ISSUE drives the memory port until mem_ack or
// timeout, DONE returns the completion pulse and masks the finished requester for
// one IDLE edge. A run-length counter forces a DMA win after MAX_CPU_RUN
// consecutive contested Cpu grants. we = 1 means write, we = 0 means read.
module mem_bus_arbiter #(
  parameter int unsigned MAX_CPU_RUN    = 4,   // 1..15
  parameter int unsigned TIMEOUT_CYCLES = 16   // 2..255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  mem_bus_arbiter_if.slave bus
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_CPU_RUN);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Sequencer state
  state_e      state_q,     state_d;
  logic        winner_q,    winner_d;     // 0 = Cpu, 1 = DMA
  logic [1:0]  mask_q,      mask_d;       // [0] Cpu, [1] DMA
  logic [3:0]  run_q,       run_d;
  logic [7:0]  tcnt_q,      tcnt_d;

  // Registered outputs
  logic        cpu_done_q,  cpu_done_d;
  logic        dma_done_q,  dma_done_d;
  logic [7:0]  rdata_q,     rdata_d;
  logic        bus_err_q,   bus_err_d;
  logic        mem_req_q,   mem_req_d;
  logic        mem_we_q,    mem_we_d;
  logic [15:0] mem_addr_q,  mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  // Arbitration helpers
  logic [1:0]  elig;
  logic        pick_dma;

  // Next-state and next-output computation; everything holds when enable is low
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    mask_d      = mask_q;
    run_d       = run_q;
    tcnt_d      = tcnt_q;
    cpu_done_d  = cpu_done_q;
    dma_done_d  = dma_done_q;
    rdata_d     = rdata_q;
    bus_err_d   = bus_err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    elig        = '0;
    pick_dma    = 1'b0;

    if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          elig   = {bus.dma_req, bus.cpu_req} & ~mask_q;
          mask_d = '0;
          if (elig != 2'b00) begin
            // Cpu wins a contest unless it has already taken RUN_MAX in a row
            pick_dma = (elig == 2'b10) ||
                       ((elig == 2'b11) && (run_q == RUN_MAX));
            if (!pick_dma && (elig == 2'b11)) begin
              run_d = run_q + 4'd1;
            end else begin
              run_d = '0;
            end
            winner_d    = pick_dma;
            mem_we_d    = pick_dma ? bus.dma_we    : bus.cpu_we;
            mem_addr_d  = pick_dma ? bus.dma_addr  : bus.cpu_addr;
            mem_wdata_d = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
            mem_req_d   = 1'b1;
            tcnt_d      = '0;
            state_d     = ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (bus.mem_ack) begin
            mem_req_d  = 1'b0;
            rdata_d    = mem_we_q ? '0 : bus.mem_rdata;
            cpu_done_d = ~winner_q;
            dma_done_d = winner_q;
            bus_err_d  = 1'b0;
            state_d    = ST_DONE;
          end else if (tcnt_q == TO_LAST) begin
            mem_req_d  = 1'b0;
            rdata_d    = 8'hFF;
            cpu_done_d = ~winner_q;
            dma_done_d = winner_q;
            bus_err_d  = 1'b1;
            state_d    = ST_DONE;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end

        ST_DONE: begin
          cpu_done_d = 1'b0;
          dma_done_d = 1'b0;
          bus_err_d  = 1'b0;
          mask_d     = winner_q ? 2'b10 : 2'b01;
          state_d    = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      winner_q    <= 1'b0;
      mask_q      <= '0;
      run_q       <= '0;
      tcnt_q      <= '0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      mask_q      <= mask_d;
      run_q       <= run_d;
      tcnt_q      <= tcnt_d;
      cpu_done_q  <= cpu_done_d;
      dma_done_q  <= dma_done_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.cpu_done  = cpu_done_q;
  assign bus.dma_done  = dma_done_q;
  assign bus.rdata     = rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (MAX_CPU_RUN = 4, TIMEOUT_CYCLES = 16).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  int   total = 0;
  int   bad   = 0;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(
    .MAX_CPU_RUN   (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Hard time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    enable        = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_mem_req",  32'(bus.mem_req),  32'h0);
    chk("rst_cpu_done", 32'(bus.cpu_done), 32'h0);
    chk("rst_dma_done", 32'(bus.dma_done), 32'h0);
    chk("rst_rdata",    32'(bus.rdata),    32'h0);
    chk("rst_bus_err",  32'(bus.bus_err),  32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    rst = 1'b0;

    // 1: Cpu read 0x1234 with immediate ack, data 0x5A
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h1234;
    bus.cpu_req   = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'h5A;
    tick();
    chk("t1_mem_req",    32'(bus.mem_req),  32'h1);
    chk("t1_mem_addr",   32'(bus.mem_addr), 32'h1234);
    chk("t1_mem_we",     32'(bus.mem_we),   32'h0);
    chk("t1_done_early", 32'(bus.cpu_done), 32'h0);
    tick();
    chk("t1_cpu_done",   32'(bus.cpu_done), 32'h1);
    chk("t1_rdata",      32'(bus.rdata),    32'h5A);
    chk("t1_bus_err",    32'(bus.bus_err),  32'h0);
    chk("t1_mem_req_lo", 32'(bus.mem_req),  32'h0);
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
    chk("t1_done_pulse", 32'(bus.cpu_done), 32'h0);

    // 2a: both requesting continuously, immediate ack -> C, D, C, D
    do_reset();
    bus.cpu_addr = 16'h1111;
    bus.dma_addr = 16'h2222;
    bus.dma_we   = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.dma_req  = 1'b1;
    bus.mem_ack  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2a_addr", 32'(bus.mem_addr), (i % 2 == 0) ? 32'h1111 : 32'h2222);
      tick();
      chk("t2a_cpu_done", 32'(bus.cpu_done), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("t2a_dma_done", 32'(bus.dma_done), (i % 2 == 0) ? 32'h0 : 32'h1);
      tick();
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    tick();

    // 2b: DMA dropped on the masked edge so every Cpu grant is contested -> C,C,C,C,D
    do_reset();
    bus.cpu_req = 1'b1;
    bus.mem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.dma_req = 1'b1;
      tick();
      chk("t2b_addr", 32'(bus.mem_addr), (k < 4) ? 32'h1111 : 32'h2222);
      tick();
      chk("t2b_cpu_done", 32'(bus.cpu_done), (k < 4) ? 32'h1 : 32'h0);
      chk("t2b_dma_done", 32'(bus.dma_done), (k < 4) ? 32'h0 : 32'h1);
      bus.dma_req = 1'b0;
      if (k == 4) bus.cpu_req = 1'b0;
      tick();
      tick();
    end
    bus.mem_ack = 1'b0;

    // 3: DMA write 0xBEEF <= 0x77, ack on the third ISSUE edge
    do_reset();
    bus.dma_we    = 1'b1;
    bus.dma_addr  = 16'hBEEF;
    bus.dma_wdata = 8'h77;
    bus.dma_req   = 1'b1;
    tick();
    chk("t3_mem_req",   32'(bus.mem_req),   32'h1);
    chk("t3_mem_we",    32'(bus.mem_we),    32'h1);
    chk("t3_mem_addr",  32'(bus.mem_addr),  32'hBEEF);
    chk("t3_mem_wdata", 32'(bus.mem_wdata), 32'h77);
    bus.dma_req = 1'b0;
    tick();
    chk("t3_hold1", 32'(bus.mem_req), 32'h1);
    tick();
    chk("t3_hold2",      32'(bus.mem_req),  32'h1);
    chk("t3_done_early", 32'(bus.dma_done), 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'hAA;
    tick();
    chk("t3_dma_done", 32'(bus.dma_done), 32'h1);
    chk("t3_cpu_done", 32'(bus.cpu_done), 32'h0);
    chk("t3_rdata",    32'(bus.rdata),    32'h00);
    chk("t3_req_lo",   32'(bus.mem_req),  32'h0);
    bus.mem_ack = 1'b0;
    tick();
    chk("t3_done_pulse", 32'(bus.dma_done), 32'h0);

    // 4: Cpu read without ack -> abort after 16 cycles of mem_req
    do_reset();
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0042;
    bus.cpu_req  = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    repeat (15) tick();
    chk("t4_still_req", 32'(bus.mem_req),  32'h1);
    chk("t4_no_done",   32'(bus.cpu_done), 32'h0);
    tick();
    chk("t4_req_lo",   32'(bus.mem_req),  32'h0);
    chk("t4_cpu_done", 32'(bus.cpu_done), 32'h1);
    chk("t4_bus_err",  32'(bus.bus_err),  32'h1);
    chk("t4_rdata",    32'(bus.rdata),    32'hFF);
    tick();
    chk("t4_err_pulse", 32'(bus.bus_err), 32'h0);

    // 5: reset mid-ISSUE, then a fresh DMA read is served normally
    do_reset();
    bus.cpu_req = 1'b1;
    tick();
    tick();
    chk("t5_in_issue", 32'(bus.mem_req), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_req_lo",  32'(bus.mem_req),  32'h0);
    chk("t5_no_done", 32'(bus.cpu_done), 32'h0);
    bus.cpu_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = 16'h3333;
    bus.dma_req   = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'h3C;
    tick();
    chk("t5_dma_addr", 32'(bus.mem_addr), 32'h3333);
    bus.dma_req = 1'b0;
    tick();
    chk("t5_dma_done", 32'(bus.dma_done), 32'h1);
    chk("t5_rdata",    32'(bus.rdata),    32'h3C);
    bus.mem_ack = 1'b0;
    tick();

    // 6: enable low for 5 edges in ISSUE freezes the timeout and ignores ack
    do_reset();
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0600;
    bus.cpu_req  = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    repeat (3) tick();
    enable        = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'h99;
    repeat (5) tick();
    chk("t6_frozen_req",  32'(bus.mem_req),  32'h1);
    chk("t6_frozen_done", 32'(bus.cpu_done), 32'h0);
    enable      = 1'b1;
    bus.mem_ack = 1'b0;
    repeat (12) tick();
    chk("t6_still_req", 32'(bus.mem_req),  32'h1);
    chk("t6_no_done",   32'(bus.cpu_done), 32'h0);
    tick();
    chk("t6_req_lo",   32'(bus.mem_req),  32'h0);
    chk("t6_cpu_done", 32'(bus.cpu_done), 32'h1);
    chk("t6_bus_err",  32'(bus.bus_err),  32'h1);
    chk("t6_rdata",    32'(bus.rdata),    32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
